// File: rtl/bitonic_sort_ctrl_if.sv
// Serial producer/consumer bus for the bitonic sort sequencer.
// The desc sideband only exists when BITONIC_CTRL_DESC_EN is defined.
interface bitonic_sort_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
`ifdef BITONIC_CTRL_DESC_EN
    logic              desc;
`endif

    // Producer/consumer side: supplies input words and takes sorted words.
    modport master (
`ifdef BITONIC_CTRL_DESC_EN
        output desc,
`endif
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done
    );

    // Sorter side.
    modport slave (
`ifdef BITONIC_CTRL_DESC_EN
        input  desc,
`endif
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// 8-entry bitonic sort sequencer: serial load, six compare layers on one
// shared bank of four compare-exchange lanes, then serial registered output.
// Optional macro BITONIC_CTRL_DESC_EN adds a desc input that reverses the
// read-out order (largest first) for the batch it was sampled with.
module bitonic_sort_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    bitonic_sort_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        layer_q, layer_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] r_q [8];
    logic [DATA_W-1:0] r_d [8];
`ifdef BITONIC_CTRL_DESC_EN
    logic              desc_q, desc_d;
`endif

    logic              in_fire;
    logic [2:0]        rd_nxt;
    logic [2:0]        lane_i [4];
    logic [2:0]        lane_j [4];
    logic              lane_asc [4];
    logic [DATA_W-1:0] lane_new_i [4];
    logic [DATA_W-1:0] lane_new_j [4];

    // Input is only offered in LOAD and never while reset is held.
    assign bus.in_ready  = (state_q == LOAD) && !reset;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != LOAD);
    assign bus.done      = in_fire && (cnt_q == 3'd7);

    // Index pairs and direction of the four lanes for the current layer.
    always_comb begin
        lane_i   = '{3'd0, 3'd2, 3'd4, 3'd6};
        lane_j   = '{3'd1, 3'd3, 3'd5, 3'd7};
        lane_asc = '{1'b1, 1'b1, 1'b1, 1'b1};
        case (layer_q)
            3'd0: lane_asc = '{1'b1, 1'b0, 1'b1, 1'b0};
            3'd1: begin
                lane_i   = '{3'd0, 3'd1, 3'd4, 3'd5};
                lane_j   = '{3'd2, 3'd3, 3'd6, 3'd7};
                lane_asc = '{1'b1, 1'b1, 1'b0, 1'b0};
            end
            3'd2: lane_asc = '{1'b1, 1'b1, 1'b0, 1'b0};
            3'd3: begin
                lane_i = '{3'd0, 3'd1, 3'd2, 3'd3};
                lane_j = '{3'd4, 3'd5, 3'd6, 3'd7};
            end
            3'd4: begin
                lane_i = '{3'd0, 3'd1, 3'd4, 3'd5};
                lane_j = '{3'd2, 3'd3, 3'd6, 3'd7};
            end
            default: ;
        endcase
    end

    // Four compare-exchange lanes; strict compares so equal words stay put.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            logic [DATA_W-1:0] a;
            logic [DATA_W-1:0] b;
            logic              swap;
            a    = r_q[lane_i[k]];
            b    = r_q[lane_j[k]];
            swap = lane_asc[k] ? (a > b) : (a < b);
            lane_new_i[k] = swap ? b : a;
            lane_new_j[k] = swap ? a : b;
        end
    end

    // Next-state logic for the load / sort / drain sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        layer_d     = layer_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < 8; k++) r_d[k] = r_q[k];
        rd_nxt = cnt_q + 3'd1;
`ifdef BITONIC_CTRL_DESC_EN
        desc_d = desc_q;
        if (desc_q) rd_nxt = 3'd6 - cnt_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    r_d[cnt_q] = bus.in_data;
`ifdef BITONIC_CTRL_DESC_EN
                    if (cnt_q == 3'd0) desc_d = bus.desc;
`endif
                    if (cnt_q == 3'd7) begin
                        state_d = SORT;
                        cnt_d   = 3'd0;
                        layer_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            SORT: begin
                for (int k = 0; k < 4; k++) begin
                    r_d[lane_i[k]] = lane_new_i[k];
                    r_d[lane_j[k]] = lane_new_j[k];
                end
                if (layer_q == 3'd5) begin
                    // Last layer pairs (0,1)..(6,7), so r[0] and r[7] come
                    // straight from lanes 0 and 3; the first word is
                    // registered without waiting an extra cycle.
                    state_d     = OUT;
                    layer_d     = 3'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = lane_new_i[0];
`ifdef BITONIC_CTRL_DESC_EN
                    if (desc_q) out_data_d = lane_new_j[3];
`endif
                end else begin
                    layer_d = layer_q + 3'd1;
                end
            end
            OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (cnt_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        cnt_d       = 3'd0;
                        state_d     = LOAD;
                    end else begin
                        cnt_d      = cnt_q + 3'd1;
                        out_data_d = r_q[rd_nxt];
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State register with synchronous clear of everything, data included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= 3'd0;
            layer_q     <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < 8; k++) r_q[k] <= '0;
`ifdef BITONIC_CTRL_DESC_EN
            desc_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            layer_q     <= layer_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int k = 0; k < 8; k++) r_q[k] <= r_d[k];
`ifdef BITONIC_CTRL_DESC_EN
            desc_q      <= desc_d;
`endif
        end
    end
endmodule
